// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces the enter button, captures the
// digit switches at the moment a press is accepted, and flags non-decimal codes.
//
// Output protocol: enter_pulse is a one-cycle strobe with no back-pressure.
// digit_out and digit_invalid are valid from the strobe cycle onward and hold
// until the next strobe. enter_level is the debounced button level.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw_digit,
  input  logic       raw_enter,
  output logic [3:0] digit_out,
  output logic       enter_pulse,
  output logic       enter_level,
  output logic       digit_invalid,
  output logic [2:0] fsm_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    ARM         = 3'd0,
    IDLE_LOW    = 3'd1,
    WAIT_HIGH   = 3'd2,
    STABLE_HIGH = 3'd3,
    WAIT_LOW    = 3'd4
  } state_t;

  logic          enter_meta;
  logic          s_enter;
  logic [3:0]    digit_meta;
  logic [3:0]    s_digit;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] cnt_inc;
  logic          accept;
  logic          release_done;

  assign fsm_state = state;

  // Saturating increment: the counter never wraps back below the target.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Two-flop synchronizers for the button and each digit bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_meta <= 1'b0;
      s_enter    <= 1'b0;
      digit_meta <= 4'd0;
      s_digit    <= 4'd0;
    end else begin
      enter_meta <= raw_enter;
      s_enter    <= enter_meta;
      digit_meta <= raw_digit;
      s_digit    <= digit_meta;
    end
  end

  // Debounce state and shared counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARM;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. A level change is accepted on the edge where the
  // incremented count of consecutive stable samples reaches the target.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    case (state)
      ARM: begin
        // Requires a sustained low before any press can be seen, so a button
        // held through reset never produces a press.
        if (s_enter) begin
          cnt_next = '0;
        end else if (cnt_inc == CNT_TARGET) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      IDLE_LOW: begin
        if (s_enter) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s_enter) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_TARGET) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      STABLE_HIGH: begin
        if (!s_enter) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s_enter) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_TARGET) begin
          state_next   = IDLE_LOW;
          cnt_next     = '0;
          release_done = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = ARM;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered outputs: strobe, debounced level and digit captured at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_pulse   <= 1'b0;
      enter_level   <= 1'b0;
      digit_out     <= 4'd0;
      digit_invalid <= 1'b0;
    end else begin
      enter_pulse <= accept;
      if (accept) begin
        enter_level   <= 1'b1;
        digit_out     <= s_digit;
        digit_invalid <= (s_digit > 4'd9);
      end else if (release_done) begin
        enter_level <= 1'b0;
      end
    end
  end

endmodule
